// File: rtl/l2pa_layer_seq.sv
// Layer sequencer for the L2PA: for each layer it clears the zero-history registers,
// steps the memShare instances in pre-V2C permutation mode, then drives the ROM load enables.
module l2pa_layer_seq #(
  parameter int SHIFT_LENGTH           = 5,
  parameter int MAX_MEMSHARE_INSTANCES = 3,
  parameter int LAYER_NUM              = 4,
  parameter int LAYER_W                = 2,
  parameter int INST_W                 = 2
) (
  input  logic                    sys_clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic                    stall_i,
  input  logic                    abort_i,
  output logic [LAYER_W-1:0]      shiftRom_addr_o,
  input  logic [SHIFT_LENGTH-1:0] shiftRom_data_i,
  output logic                    is_preV2CPerm_o,
  output logic [SHIFT_LENGTH-1:0] shiftROM_load_en_o,
  output logic                    preV2CPerm_l2pa_rstn_o,
  output logic [INST_W-1:0]       memShare_inst_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYER_NUM - 1);
  localparam logic [INST_W-1:0]  LAST_INST  = INST_W'(MAX_MEMSHARE_INSTANCES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_RST  = 3'd1,
    PRE_PERM = 3'd2,
    MSG_PASS = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                  state,     state_nxt;
  logic [LAYER_W-1:0]      layer_cnt, layer_nxt;
  logic [INST_W-1:0]       inst_cnt,  inst_nxt;
  logic [SHIFT_LENGTH-1:0] pat_p0,    pat_nxt;

  // State, counter and pattern registers
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      layer_cnt <= '0;
      inst_cnt  <= '0;
      pat_p0    <= '0;
    end else begin
      state     <= state_nxt;
      layer_cnt <= layer_nxt;
      inst_cnt  <= inst_nxt;
      pat_p0    <= pat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    layer_nxt = layer_cnt;
    inst_nxt  = inst_cnt;
    pat_nxt   = pat_p0;
    unique case (state)
      IDLE: begin
        layer_nxt = '0;
        inst_nxt  = '0;
        if (start_i) state_nxt = PRE_RST;
      end
      PRE_RST: begin
        inst_nxt  = '0;
        state_nxt = PRE_PERM;
      end
      PRE_PERM: begin
        if (!stall_i) begin
          // ROM data for this layer lands one cycle after the PRE_RST address
          if (inst_cnt == '0) pat_nxt = shiftRom_data_i;
          if (inst_cnt == LAST_INST) begin
            inst_nxt  = '0;
            state_nxt = MSG_PASS;
          end else begin
            inst_nxt  = inst_cnt + 1'b1;
          end
        end
      end
      MSG_PASS: begin
        if (!stall_i) begin
          if (layer_cnt == LAST_LAYER) begin
            state_nxt = DONE;
          end else begin
            layer_nxt = layer_cnt + 1'b1;
            state_nxt = PRE_RST;
          end
        end
      end
      DONE: begin
        layer_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Abort overrides every transition, including stall holds
    if (abort_i) begin
      state_nxt = IDLE;
      layer_nxt = '0;
      inst_nxt  = '0;
    end
  end

  // Outputs decoded from registered state; load enables are also masked by stall
  // so a stalled message-pass cycle never loads the combiner twice.
  assign shiftRom_addr_o        = layer_cnt;
  assign is_preV2CPerm_o        = (state == PRE_PERM);
  assign preV2CPerm_l2pa_rstn_o = (state != PRE_RST);
  assign memShare_inst_o        = (state == PRE_PERM) ? inst_cnt : '0;
  assign busy_o                 = (state != IDLE);
  assign done_o                 = (state == DONE);
  assign shiftROM_load_en_o     = ((state == MSG_PASS) && !stall_i) ? pat_p0 : '0;

endmodule

// File: tb/tb_l2pa_layer_seq.sv
// Directed bench for l2pa_layer_seq with a two-layer configuration and a registered ROM model.
module tb_l2pa_layer_seq;

  logic       sys_clk;
  logic       rstn;
  logic       start_i;
  logic       stall_i;
  logic       abort_i;
  logic [1:0] shiftRom_addr_o;
  logic [4:0] shiftRom_data_i;
  logic       is_preV2CPerm_o;
  logic [4:0] shiftROM_load_en_o;
  logic       preV2CPerm_l2pa_rstn_o;
  logic [1:0] memShare_inst_o;
  logic       busy_o;
  logic       done_o;

  int vecs = 0;
  int errs = 0;

  logic [4:0] rom [0:3];

  l2pa_layer_seq #(
    .SHIFT_LENGTH(5),
    .MAX_MEMSHARE_INSTANCES(3),
    .LAYER_NUM(2),
    .LAYER_W(2),
    .INST_W(2)
  ) dut (
    .sys_clk(sys_clk),
    .rstn(rstn),
    .start_i(start_i),
    .stall_i(stall_i),
    .abort_i(abort_i),
    .shiftRom_addr_o(shiftRom_addr_o),
    .shiftRom_data_i(shiftRom_data_i),
    .is_preV2CPerm_o(is_preV2CPerm_o),
    .shiftROM_load_en_o(shiftROM_load_en_o),
    .preV2CPerm_l2pa_rstn_o(preV2CPerm_l2pa_rstn_o),
    .memShare_inst_o(memShare_inst_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    rom[0] = 5'b10101;
    rom[1] = 5'b01110;
    rom[2] = 5'b00000;
    rom[3] = 5'b00000;
  end

  always @(posedge sys_clk) shiftRom_data_i <= rom[shiftRom_addr_o];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic b, input logic d, input logic p,
                             input logic r, input logic [1:0] inst, input logic [4:0] ld,
                             input int addr);
    chk({tag, ".busy"}, 32'(busy_o), 32'(b));
    chk({tag, ".done"}, 32'(done_o), 32'(d));
    chk({tag, ".preperm"}, 32'(is_preV2CPerm_o), 32'(p));
    chk({tag, ".l2pa_rstn"}, 32'(preV2CPerm_l2pa_rstn_o), 32'(r));
    chk({tag, ".inst"}, 32'(memShare_inst_o), 32'(inst));
    chk({tag, ".load_en"}, 32'(shiftROM_load_en_o), 32'(ld));
    if (addr >= 0) chk({tag, ".addr"}, 32'(shiftRom_addr_o), 32'(addr));
  endtask

  // One clock cycle: inputs applied just after the edge, outputs checked 1 time unit later
  task automatic cyc(input logic s, input logic st, input logic ab);
    @(posedge sys_clk);
    #1;
    start_i = s;
    stall_i = st;
    abort_i = ab;
    #1;
  endtask

  initial begin
    start_i = 1'b0;
    stall_i = 1'b0;
    abort_i = 1'b0;
    rstn    = 1'b1;
    #2 rstn = 1'b0;
    #1 expect_outs("reset", 0, 0, 0, 1, 2'd0, 5'h00, 0);
    @(posedge sys_clk);
    #3 rstn = 1'b1;

    // Plain two-layer pass; start during busy and on the done cycle is ignored
    cyc(1, 0, 0); expect_outs("a_idle",      0, 0, 0, 1, 2'd0, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("a_prerst0",   1, 0, 0, 0, 2'd0, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("a_perm0_i0",  1, 0, 1, 1, 2'd0, 5'h00, 0);
    cyc(1, 0, 0); expect_outs("a_perm0_i1",  1, 0, 1, 1, 2'd1, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("a_perm0_i2",  1, 0, 1, 1, 2'd2, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("a_msg0",      1, 0, 0, 1, 2'd0, 5'h15, 0);
    cyc(0, 0, 0); expect_outs("a_prerst1",   1, 0, 0, 0, 2'd0, 5'h00, 1);
    cyc(0, 0, 0); expect_outs("a_perm1_i0",  1, 0, 1, 1, 2'd0, 5'h00, 1);
    cyc(0, 0, 0); expect_outs("a_perm1_i1",  1, 0, 1, 1, 2'd1, 5'h00, 1);
    cyc(0, 0, 0); expect_outs("a_perm1_i2",  1, 0, 1, 1, 2'd2, 5'h00, 1);
    cyc(0, 0, 0); expect_outs("a_msg1",      1, 0, 0, 1, 2'd0, 5'h0E, 1);
    cyc(1, 0, 0); expect_outs("a_done",      1, 1, 0, 1, 2'd0, 5'h00, -1);
    cyc(1, 0, 0); expect_outs("a_idle2",     0, 0, 0, 1, 2'd0, 5'h00, 0);

    // Stalls in PRE_PERM (2 cycles), PRE_RST (no effect), MSG_PASS (1 cycle) and DONE (no effect)
    cyc(0, 0, 0); expect_outs("b_prerst0",   1, 0, 0, 0, 2'd0, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("b_perm_i0",   1, 0, 1, 1, 2'd0, 5'h00, 0);
    cyc(0, 1, 0); expect_outs("b_perm_i1a",  1, 0, 1, 1, 2'd1, 5'h00, 0);
    cyc(0, 1, 0); expect_outs("b_perm_i1b",  1, 0, 1, 1, 2'd1, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("b_perm_i1c",  1, 0, 1, 1, 2'd1, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("b_perm_i2",   1, 0, 1, 1, 2'd2, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("b_msg0",      1, 0, 0, 1, 2'd0, 5'h15, 0);
    cyc(0, 1, 0); expect_outs("b_prerst1",   1, 0, 0, 0, 2'd0, 5'h00, 1);
    cyc(0, 0, 0); expect_outs("b_perm1_i0",  1, 0, 1, 1, 2'd0, 5'h00, 1);
    cyc(0, 0, 0); expect_outs("b_perm1_i1",  1, 0, 1, 1, 2'd1, 5'h00, 1);
    cyc(0, 0, 0); expect_outs("b_perm1_i2",  1, 0, 1, 1, 2'd2, 5'h00, 1);
    cyc(0, 1, 0); expect_outs("c_msg_stall", 1, 0, 0, 1, 2'd0, 5'h00, 1);
    cyc(0, 0, 0); expect_outs("c_msg_go",    1, 0, 0, 1, 2'd0, 5'h0E, 1);
    cyc(0, 1, 0); expect_outs("c_done",      1, 1, 0, 1, 2'd0, 5'h00, -1);
    cyc(1, 0, 0); expect_outs("c_idle",      0, 0, 0, 1, 2'd0, 5'h00, 0);

    // Abort (with a simultaneous stall) in the second PRE_PERM cycle of layer 1
    cyc(0, 0, 0); expect_outs("d_prerst0",   1, 0, 0, 0, 2'd0, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("d_perm0_i0",  1, 0, 1, 1, 2'd0, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("d_perm0_i1",  1, 0, 1, 1, 2'd1, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("d_perm0_i2",  1, 0, 1, 1, 2'd2, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("d_msg0",      1, 0, 0, 1, 2'd0, 5'h15, 0);
    cyc(0, 0, 0); expect_outs("d_prerst1",   1, 0, 0, 0, 2'd0, 5'h00, 1);
    cyc(0, 0, 0); expect_outs("d_perm1_i0",  1, 0, 1, 1, 2'd0, 5'h00, 1);
    cyc(0, 1, 1); expect_outs("d_perm1_i1",  1, 0, 1, 1, 2'd1, 5'h00, 1);
    cyc(0, 0, 0); expect_outs("d_aborted",   0, 0, 0, 1, 2'd0, 5'h00, 0);
    cyc(1, 0, 0); expect_outs("d_idle",      0, 0, 0, 1, 2'd0, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("d_restart",   1, 0, 0, 0, 2'd0, 5'h00, 0);

    // Asynchronous reset during MSG_PASS, then immediate restart
    cyc(0, 0, 0); expect_outs("e_perm_i0",   1, 0, 1, 1, 2'd0, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("e_perm_i1",   1, 0, 1, 1, 2'd1, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("e_perm_i2",   1, 0, 1, 1, 2'd2, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("e_msg0",      1, 0, 0, 1, 2'd0, 5'h15, 0);
    #1 rstn = 1'b0;
    #1 expect_outs("e_async_rst",            0, 0, 0, 1, 2'd0, 5'h00, 0);
    #1 rstn = 1'b1;
    cyc(1, 0, 0); expect_outs("e_idle",      0, 0, 0, 1, 2'd0, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("e_prerst0",   1, 0, 0, 0, 2'd0, 5'h00, 0);

    // Run the rest of the pass, then abort in DONE: done_o still pulses once
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0);
      chk("f_run.busy", 32'(busy_o), 32'd1);
      chk("f_run.done", 32'(done_o), 32'd0);
    end
    cyc(0, 0, 1); expect_outs("f_done_abort", 1, 1, 0, 1, 2'd0, 5'h00, -1);
    cyc(0, 0, 0); expect_outs("f_idle",       0, 0, 0, 1, 2'd0, 5'h00, 0);
    cyc(0, 0, 0); expect_outs("f_idle2",      0, 0, 0, 1, 2'd0, 5'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
